// File: rtl/invert_if.sv
// -----------------------------------------------------------------------------
// invert_if
//   Serial bit-lane bundle around the invert negator.
//   i : serial input bit, LSB first, one bit per clock
//   y : serial two's-complement output bit
//   master drives i and observes y; slave is the negator side.
// -----------------------------------------------------------------------------
interface invert_if;
  logic i;
  logic y;

  modport master (output i, input y);
  modport slave  (input i, output y);
endinterface

// File: rtl/invert.sv
// -----------------------------------------------------------------------------
// invert
//   Bit-serial two's-complement negator. An LSB-first serial word on i is
//   turned into -word on y: bits are copied up to and including the first 1
//   of the word, every later bit is inverted. The FSM re-arms by itself every
//   WORD_LEN sampled bits, so words may follow back to back with no gap.
//
// Ports (fixed positional order):
//   i      in  1  serial input bit, LSB first
//   r      in  1  asynchronous active-low reset
//   t_clk  in  1  clock, rising-edge active
//   y      out 1  serial negated bit (forced 0 while r=0)
//
// Parameters:
//   WORD_LEN  bits per serial word (>=1)
//   CNT_W     bit-counter width, derived from WORD_LEN
//
// Build option INVERT_REGOUT_EN:
//   undefined : y is the combinational Mealy output, zero latency
//   defined   : y is registered, one cycle of latency, flop cleared by r
//   The counter and FSM behave identically in both builds.
//
// r is not synchronised here; the caller releases it away from t_clk edges.
// -----------------------------------------------------------------------------
module invert #(
  parameter int WORD_LEN = 8
) (
  input  logic i,
  input  logic r,
  input  logic t_clk,
  output logic y
);

  localparam int CNT_W = $clog2(WORD_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_LEN - 1);

  typedef enum logic {
    COPY = 1'b0,   // no 1 seen yet in the current word
    NEG  = 1'b1    // first 1 already passed, invert the rest
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_y_nxt;

  // State and bit counter
  always_ff @(posedge t_clk or negedge r) begin
    if (!r) begin
      r_state <= COPY;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state and Mealy output.
  // The first 1 of a word still sees COPY, so it passes through unchanged.
  // The word boundary takes priority over i, which is why a 1 in the last
  // bit never carries NEG into the next word.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_y_nxt     = (r_state == NEG) ? ~i : i;

    if (r_cnt == LAST_BIT) begin
      w_cnt_nxt   = '0;
      w_state_nxt = COPY;
    end else begin
      w_cnt_nxt = r_cnt + CNT_W'(1);
      if ((r_state == COPY) && i) begin
        w_state_nxt = NEG;
      end
    end
  end

`ifdef INVERT_REGOUT_EN
  logic r_y;

  // Registered output stage, using the pre-edge state
  always_ff @(posedge t_clk or negedge r) begin
    if (!r) begin
      r_y <= 1'b0;
    end else begin
      r_y <= w_y_nxt;
    end
  end

  assign y = r_y;
`else
  // Reset gating keeps y at 0 while r is low, whatever i is doing
  assign y = r ? w_y_nxt : 1'b0;
`endif

endmodule

// File: tb/tb_invert.sv
// -----------------------------------------------------------------------------
// tb_invert
//   Self-checking bench for invert (WORD_LEN=8). A reference model tracks the
//   position in the word and the bits received so far; the expected output
//   bit k is bit k of the two's-complement negation of the k+1-bit prefix.
//   Literal word-level expectations pin the model; randomized streams with
//   occasional reset pulses exercise the rest.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_invert;

  localparam int WL = 8;
`ifdef INVERT_REGOUT_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic t_clk = 1'b0;
  logic r     = 1'b0;
  invert_if sif ();

  int n_cmp  = 0;
  int n_fail = 0;
  bit done   = 1'b0;

  invert #(.WORD_LEN(WL)) dut (
    .i     (sif.i),
    .r     (r),
    .t_clk (t_clk),
    .y     (sif.y)
  );

  always #5 t_clk = ~t_clk;

  function automatic void check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model plus per-cycle compare, evaluated at the falling edge.
  int   m_k      = 0;     // bit index within the current word
  int   m_prefix = 0;     // bits 0..m_k-1 received so far
  logic m_dly    = 1'b0;  // expectation from the previous cycle (registered build)

  always @(negedge t_clk) begin
    if (!done) begin
      if (!r) begin
        check("y_in_reset", int'(sif.y), 0);
        m_k      = 0;
        m_prefix = 0;
        m_dly    = 1'b0;
      end else begin
        int   p;
        int   m;
        int   negv;
        logic e;
        p    = m_prefix | (int'(sif.i) << m_k);
        m    = 1 << (m_k + 1);
        negv = (m - p) % m;
        e    = negv[m_k];
        if (LAT == 0) check("y_model", int'(sif.y), int'(e));
        else          check("y_model", int'(sif.y), int'(m_dly));
        m_dly = e;
        if (m_k == WL - 1) begin
          m_k      = 0;
          m_prefix = 0;
        end else begin
          m_k      = m_k + 1;
          m_prefix = p;
        end
      end
    end
  end

  // All driver tasks start and end at posedge+1.
  task automatic drive_bit(input logic b, output logic yb);
    sif.i = b;
    #3 yb = sif.y;
    @(posedge t_clk);
    #1;
  endtask

  // Reset held across a full cycle with i=1, released at posedge+1.
  task automatic do_reset();
    r     = 1'b0;
    sif.i = 1'b1;
    #3 check("y_reset_i1", int'(sif.y), 0);
    @(posedge t_clk);
    #1 r = 1'b1;
  endtask

  // Send words back to back and return the captured output words.
  task automatic send_words(input logic [7:0] w [], output logic [7:0] got []);
    logic yb;
    logic cap[$];
    got = new[w.size()];
    foreach (w[n]) begin
      for (int b = 0; b < WL; b++) begin
        drive_bit(w[n][b], yb);
        cap.push_back(yb);
      end
    end
    for (int x = 0; x < LAT; x++) begin
      drive_bit(1'b0, yb);
      cap.push_back(yb);
    end
    foreach (w[n]) begin
      for (int b = 0; b < WL; b++) got[n][b] = cap[n*WL + b + LAT];
    end
  endtask

  initial begin
    logic       yb;
    logic [7:0] win [];
    logic [7:0] wout[];
    logic [7:0] lit [];

    sif.i = 1'b0;
    #12;
    @(posedge t_clk);
    #1;

    // Reset release with i=1 held: COPY passes the 1 straight through
    do_reset();
    drive_bit(1'b1, yb);
    check("y_after_release", int'(yb), (LAT == 0) ? 1 : 0);

    // Directed words, including back-to-back 6 then 1
    do_reset();
    win = new[6];
    lit = new[6];
    win = '{8'd6, 8'd1, 8'h00, 8'h80, 8'h01, 8'd6};
    lit = '{8'hFA, 8'hFF, 8'h00, 8'h80, 8'hFF, 8'hFA};
    send_words(win, wout);
    foreach (win[n]) check($sformatf("word_%0d_in_%0h", n, win[n]), int'(wout[n]), int'(lit[n]));

    // Reset mid-word after bit 3 of word 6, then a fresh word 6
    do_reset();
    for (int b = 0; b < 4; b++) drive_bit(win[0][b], yb);
    do_reset();
    win = new[1];
    win[0] = 8'd6;
    send_words(win, wout);
    check("word_after_midreset", int'(wout[0]), 8'hFA);

    // Randomized streams with occasional reset pulses, checked word-wise too
    do_reset();
    for (int t = 0; t < 40; t++) begin
      win = new[4];
      foreach (win[n]) win[n] = 8'($urandom_range(0, 255));
      send_words(win, wout);
      foreach (win[n]) check("rand_word", int'(wout[n]), int'(8'(-win[n])));
      if ($urandom_range(0, 4) == 0) do_reset();
      else if (LAT != 0) begin
        // the flush bit of the registered build consumed bit 0 of a word
        do_reset();
      end
      for (int b = 0; b < int'($urandom_range(0, 5)); b++) drive_bit(1'($urandom), yb);
      do_reset();
    end

    done = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no completion, expected finish before 2ms");
    $fatal(1, "timeout");
  end

endmodule
